// File: rtl/ram_arbiter_if.sv
// One requester port of the byte-lane RAM arbiter: request/write bus from the
// requester, grant, error and aligned load data back from the arbiter.
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        uns;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, size, uns,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, size, uns,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-lane RAM with one-cycle
// read latency; handles sub-word alignment, lane steering and load extension.
module ram_arbiter #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic [3:0]        ram_wen,
  output logic [MEM_AW-1:0] ram_w_addr,
  output logic [31:0]       ram_w_data,
  output logic              ram_ren,
  output logic [MEM_AW-1:0] ram_r_addr,
  input  logic [31:0]       ram_r_data
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t      state_reg;
  logic        last_reg;
  logic        owner_reg;
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;

  logic        idle;
  logic        gnt0;
  logic        gnt1;
  logic        granted;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic        illegal;
  logic        do_write;
  logic        do_read;
  logic [3:0]  wen_mask;
  logic [31:0] lane_data;
  logic        rvalid;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  // last_reg holds the most recent winner, so a tie goes to the other one.
  assign idle    = (state_reg == IDLE) && !rst;
  assign gnt0    = idle && m0.req && (!m1.req || last_reg);
  assign gnt1    = idle && m1.req && (!m0.req || !last_reg);
  assign granted = gnt0 || gnt1;

  assign sel_we    = gnt1 ? m1.we    : m0.we;
  assign sel_addr  = gnt1 ? m1.addr  : m0.addr;
  assign sel_wdata = gnt1 ? m1.wdata : m0.wdata;
  assign sel_size  = gnt1 ? m1.size  : m0.size;
  assign sel_uns   = gnt1 ? m1.uns   : m0.uns;

  assign unused_addr_bits = ^sel_addr[31:MEM_AW+2];

  always_comb begin
    illegal = 1'b0;
    case (sel_size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = sel_addr[0];
      2'b10:   illegal = (sel_addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  assign do_write = granted && sel_we && !illegal;
  assign do_read  = granted && !sel_we && !illegal;

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;
  assign m0.err = gnt0 && illegal;
  assign m1.err = gnt1 && illegal;

  always_comb begin
    wen_mask = 4'b0000;
    case (sel_size)
      2'b00:   wen_mask = 4'b0001 << sel_addr[1:0];
      2'b01:   wen_mask = sel_addr[1] ? 4'b1100 : 4'b0011;
      default: wen_mask = 4'b1111;
    endcase
  end

  // Replicate narrow stores across all lanes; ram_wen picks the live ones.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        lane_data[8*gi +: 8] = sel_wdata[8*gi +: 8];
        if (sel_size == 2'b00)
          lane_data[8*gi +: 8] = sel_wdata[7:0];
        else if (sel_size == 2'b01)
          lane_data[8*gi +: 8] = sel_wdata[8*(gi%2) +: 8];
      end
      assign ram_w_data[8*gi +: 8] = do_write ? lane_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign ram_wen    = do_write ? wen_mask : 4'b0000;
  assign ram_w_addr = do_write ? sel_addr[MEM_AW+1:2] : '0;
  assign ram_ren    = do_read;
  assign ram_r_addr = do_read ? sel_addr[MEM_AW+1:2] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      owner_reg <= 1'b0;
      off_reg   <= 2'b00;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (granted)
            last_reg <= gnt1;
          if (do_read) begin
            owner_reg <= gnt1;
            off_reg   <= sel_addr[1:0];
            size_reg  <= sel_size;
            uns_reg   <= sel_uns;
            state_reg <= RD_WAIT;
          end
        end
        RD_WAIT: state_reg <= IDLE;
      endcase
    end
  end

  // RAM data lands during RD_WAIT; steer and extend it using the captured offset.
  always_comb begin
    rd_byte = ram_r_data[7:0];
    case (off_reg)
      2'b00:   rd_byte = ram_r_data[7:0];
      2'b01:   rd_byte = ram_r_data[15:8];
      2'b10:   rd_byte = ram_r_data[23:16];
      default: rd_byte = ram_r_data[31:24];
    endcase
  end

  assign rd_half = off_reg[1] ? ram_r_data[31:16] : ram_r_data[15:0];

  always_comb begin
    rd_data = ram_r_data;
    case (size_reg)
      2'b00:   rd_data = {{24{!uns_reg && rd_byte[7]}}, rd_byte};
      2'b01:   rd_data = {{16{!uns_reg && rd_half[15]}}, rd_half};
      default: rd_data = ram_r_data;
    endcase
  end

  assign rvalid    = (state_reg == RD_WAIT) && !rst;
  assign m0.rvalid = rvalid && !owner_reg;
  assign m1.rvalid = rvalid && owner_reg;
  assign m0.rdata  = m0.rvalid ? rd_data : 32'h0;
  assign m1.rdata  = m1.rvalid ? rd_data : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a small behavioural RAM behind the arbiter and
// hand-computed expectations for grants, lane steering and load extension.
module tb_ram_arbiter;
  localparam int MEM_AW = 12;

  logic              clk;
  logic              rst;
  logic [3:0]        ram_wen;
  logic [MEM_AW-1:0] ram_w_addr;
  logic [31:0]       ram_w_data;
  logic              ram_ren;
  logic [MEM_AW-1:0] ram_r_addr;
  logic [31:0]       ram_r_data;
  logic [31:0]       mem [0:(1<<MEM_AW)-1];

  int n_checks = 0;
  int n_pass   = 0;

  ram_arbiter_if m0_if ();
  ram_arbiter_if m1_if ();

  ram_arbiter #(.MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .ram_wen    (ram_wen),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_ren    (ram_ren),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ren)
      ram_r_data <= mem[ram_r_addr];
    for (int i = 0; i < 4; i++)
      if (ram_wen[i])
        mem[ram_w_addr][8*i +: 8] <= ram_w_data[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=0x%08h", tag, got);
    end else begin
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int n, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    if (n == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr;
      m0_if.wdata = wdata; m0_if.size = size; m0_if.uns = uns;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr;
      m1_if.wdata = wdata; m1_if.size = size; m1_if.uns = uns;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    ram_r_data = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    rst = 1'b1;
    idle_all();
    drive(0, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 2'b10, 1'b0);
    step(); step();
    mid();
    check("rst_gnt0",   {31'h0, m0_if.gnt},    32'h0);
    check("rst_wen",    {28'h0, ram_wen},      32'h0);
    check("rst_wdata",  ram_w_data,            32'h0);
    check("rst_waddr",  {20'h0, ram_w_addr},   32'h0);
    check("rst_rvalid", {31'h0, m0_if.rvalid}, 32'h0);

    // Byte write to byte address 6.
    step(); rst = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h6, 32'h000000A5, 2'b00, 1'b0);
    mid();
    check("bw_gnt0",  {31'h0, m0_if.gnt},  32'h1);
    check("bw_wen",   {28'h0, ram_wen},    32'h4);
    check("bw_waddr", {20'h0, ram_w_addr}, 32'h1);
    check("bw_wdata", ram_w_data,          32'hA5A5A5A5);
    check("bw_err0",  {31'h0, m0_if.err},  32'h0);

    step(); idle_all();
    drive(1, 1'b1, 1'b1, 32'h4, 32'h80770000, 2'b10, 1'b0);
    mid();
    check("ww_gnt1",  {31'h0, m1_if.gnt}, 32'h1);
    check("ww_wen",   {28'h0, ram_wen},   32'hF);
    check("ww_wdata", ram_w_data,         32'h80770000);

    // Half-word write lane steering (upper half), to word 3.
    step(); idle_all();
    drive(0, 1'b1, 1'b1, 32'hE, 32'h0000BEEF, 2'b01, 1'b0);
    mid();
    check("hw_wen",   {28'h0, ram_wen}, 32'hC);
    check("hw_wdata", ram_w_data,       32'hBEEFBEEF);

    // Signed half read of 0x8077 from byte address 6.
    step(); idle_all();
    drive(1, 1'b1, 1'b0, 32'h6, 32'h0, 2'b01, 1'b0);
    mid();
    check("hr_gnt1",   {31'h0, m1_if.gnt},    32'h1);
    check("hr_ren",    {31'h0, ram_ren},      32'h1);
    check("hr_raddr",  {20'h0, ram_r_addr},   32'h1);
    check("hr_rv_early", {31'h0, m1_if.rvalid}, 32'h0);
    step(); idle_all();
    mid();
    check("hr_rvalid1", {31'h0, m1_if.rvalid}, 32'h1);
    check("hr_rdata_s", m1_if.rdata,           32'hFFFF8077);
    check("hr_rvalid0", {31'h0, m0_if.rvalid}, 32'h0);

    step();
    drive(1, 1'b1, 1'b0, 32'h6, 32'h0, 2'b01, 1'b1);
    mid();
    check("hru_gnt1",   {31'h0, m1_if.gnt},    32'h1);
    check("hru_rdata0", m1_if.rdata,           32'h0);
    step(); idle_all();
    mid();
    check("hru_rvalid1", {31'h0, m1_if.rvalid}, 32'h1);
    check("hru_rdata_u", m1_if.rdata,           32'h00008077);
    step(); mid();
    check("hru_rv_drop", {31'h0, m1_if.rvalid}, 32'h0);

    // Byte loads: lane 3 (0x80) signed, lane 2 (0x77), upper half of word 3.
    drive(0, 1'b1, 1'b0, 32'h7, 32'h0, 2'b00, 1'b0);
    step(); idle_all(); mid();
    check("br7_rdata", m0_if.rdata, 32'hFFFFFF80);
    step();
    drive(0, 1'b1, 1'b0, 32'h7, 32'h0, 2'b00, 1'b1);
    step(); idle_all(); mid();
    check("br7u_rdata", m0_if.rdata, 32'h00000080);
    step();
    drive(0, 1'b1, 1'b0, 32'h6, 32'h0, 2'b00, 1'b0);
    step(); idle_all(); mid();
    check("br6_rdata", m0_if.rdata, 32'h00000077);
    step();
    drive(0, 1'b1, 1'b0, 32'hC, 32'h0, 2'b10, 1'b0);
    step(); idle_all(); mid();
    check("wr3_rdata", m0_if.rdata, 32'hBEEF0000);

    // Illegal accesses: misaligned word, size 11, odd half write.
    step();
    drive(0, 1'b1, 1'b0, 32'h2, 32'h0, 2'b10, 1'b0);
    mid();
    check("ilw_gnt0", {31'h0, m0_if.gnt}, 32'h1);
    check("ilw_err0", {31'h0, m0_if.err}, 32'h1);
    check("ilw_ren",  {31'h0, ram_ren},   32'h0);
    step(); idle_all(); mid();
    check("ilw_rvalid", {31'h0, m0_if.rvalid}, 32'h0);
    step();
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
    mid();
    check("il3_err0", {31'h0, m0_if.err}, 32'h1);
    check("il3_ren",  {31'h0, ram_ren},   32'h0);
    step(); idle_all(); mid();
    check("il3_rvalid", {31'h0, m0_if.rvalid}, 32'h0);
    step();
    drive(1, 1'b1, 1'b1, 32'h5, 32'h1234, 2'b01, 1'b0);
    mid();
    check("ilh_err1", {31'h0, m1_if.err}, 32'h1);
    check("ilh_wen",  {28'h0, ram_wen},   32'h0);

    // Request arriving during RD_WAIT waits one cycle.
    step(); idle_all();
    drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
    mid();
    check("rw_gnt0", {31'h0, m0_if.gnt}, 32'h1);
    step(); idle_all();
    drive(1, 1'b1, 1'b1, 32'h8, 32'h12345678, 2'b10, 1'b0);
    mid();
    check("rw_gnt1_blk", {31'h0, m1_if.gnt},    32'h0);
    check("rw_wen_blk",  {28'h0, ram_wen},      32'h0);
    check("rw_rvalid0",  {31'h0, m0_if.rvalid}, 32'h1);
    check("rw_rdata0",   m0_if.rdata,           32'h80770000);
    step(); mid();
    check("rw_gnt1", {31'h0, m1_if.gnt}, 32'h1);
    check("rw_wen",  {28'h0, ram_wen},   32'hF);

    // Round-robin from reset with both requesters holding word writes.
    step(); idle_all(); rst = 1'b1;
    step(); rst = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h10, 32'hAAAA0000, 2'b10, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h14, 32'hBBBB1111, 2'b10, 1'b0);
    for (int c = 0; c < 4; c++) begin
      mid();
      check($sformatf("rr_gnt_c%0d", c), {30'h0, m1_if.gnt, m0_if.gnt},
            (c % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end

    // Reset during RD_WAIT drops the read and re-favours m0.
    idle_all();
    drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
    mid();
    check("rr_rd_gnt0", {31'h0, m0_if.gnt}, 32'h1);
    step(); idle_all(); rst = 1'b1;
    mid();
    check("rst_rd_rvalid", {31'h0, m0_if.rvalid}, 32'h0);
    check("rst_rd_rdata",  m0_if.rdata,           32'h0);
    step(); rst = 1'b0;
    mid();
    check("post_rvalid", {31'h0, m0_if.rvalid}, 32'h0);
    check("post_ren",    {31'h0, ram_ren},      32'h0);
    step();
    drive(0, 1'b1, 1'b1, 32'h18, 32'h1, 2'b10, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h1C, 32'h2, 2'b10, 1'b0);
    mid();
    check("post_rr_gnt", {30'h0, m1_if.gnt, m0_if.gnt}, 32'h1);
    step(); idle_all();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
